dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller for the RISC-V core; successor to the fixed single-cycle data memory.
- Adds a valid/ready request handshake, a configurable wait-state count, byte/half/word little-endian access with sign or zero extension, and misaligned-access handling.
- Sits between the core's load/store stage and the memory array; the core stalls while req_ready is low.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 64, number of 32-bit words; power of 2, minimum 4.
- LATENCY, 1, wait cycles between acceptance and the response state; range 0..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load (lbu/lhu).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low bits are used for byte/half.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned or reserved-size access, valid with rsp_valid.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - req_ready=1; rsp_valid, rsp_rdata, rsp_err and busy are all 0.
  - Wait counter is cleared.
  - Memory contents are not cleared.
  - A pending store is discarded if reset asserts mid-operation.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture we/size/unsigned/addr/wdata. Go to WAIT if LATENCY>0, otherwise to RESP.
  - WAIT: counter counts 1..LATENCY; go to RESP on the edge where the counter equals LATENCY.
  - RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. No request is accepted in RESP.
- Latency:
  - rsp_valid rises LATENCY+1 cycles after the accepting edge.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- Array update:
  - The store write and the load read both take effect on the edge that enters RESP.
  - rsp_rdata is registered and holds its value until the next RESP.
- Indexing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Byte lanes (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits 15:0 or 31:16).
  - A store writes only the selected lanes; all other bytes are preserved.
- Load extension:
  - Byte/half loads are sign-extended from bit 7/15 when req_unsigned=0, and zero-extended when req_unsigned=1.
  - For word loads, req_unsigned is ignored.
- Error handling:
  - Misalignment is defined as: half with addr[0]=1, or word with addr[1:0]!=0.
  - A reserved size (11) is handled as defined under Optional Feature.
- Simultaneous events: req_valid while busy is ignored; the requester must hold its request until it sees req_ready=1.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - A misaligned or reserved-size request does not modify memory.
  - It returns rsp_rdata=0 and rsp_err=1 with rsp_valid, with normal latency.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are aligned down: the low bit is forced to 0 for half, the low two bits for word.
  - Size 11 is treated as word.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, busy=0, rsp_rdata=0.
- Word round trip (LATENCY=1):
  - sw 0xDEADBEEF to 0x10 -> rsp_valid exactly 2 cycles after acceptance, rsp_err=0.
  - lw from 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte/half stores and loads:
  - sb 0x80 to 0x13 over 0x00000000 -> lw from 0x10 returns 0x80000000.
  - lb from 0x13 -> 0xFFFFFF80; lbu from 0x13 -> 0x00000080.
  - sh 0x1234 to 0x12 -> lw returns 0x12340000.
- Wrap and latency sweep:
  - With DEPTH_WORDS=64: sw 0xA5A5A5A5 to 0x100 -> lw from 0x000 returns 0xA5A5A5A5.
  - Repeat with LATENCY=0 and LATENCY=7 -> rsp_valid at 1 and 8 cycles respectively.
- Misaligned access:
  - With DMEM_ERR_EN: lw from 0x11 -> rsp_err=1, rsp_rdata=0; sw to 0x11 -> memory at 0x10 is unchanged.
  - Without DMEM_ERR_EN: lw from 0x11 returns the word at 0x10, rsp_err=0.
- Reset mid-operation: accept sw 0x11112222 to 0x20 with LATENCY=3, pull reset low in WAIT -> state IDLE, lw from 0x20 returns its prior value.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory controller for the RISC-V load/store stage.
//
// Wraps a DEPTH_WORDS x 32 array behind a valid/ready request handshake.
// Every accepted request runs IDLE -> WAIT (LATENCY cycles, skipped when
// LATENCY==0) -> RESP, so a response appears LATENCY+1 edges after the
// accepting edge and back-to-back throughput is one per LATENCY+2 cycles.
// Byte/half/word accesses are little-endian; loads sign- or zero-extend.
//
// Build option: `define DMEM_ERR_EN to report misaligned / reserved-size
// requests through rsp_err (no memory update, rdata=0). Without it rsp_err
// is 0, misaligned addresses are aligned down and size 11 acts as word.
//
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 store, 0 load
//   req_size              00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned          zero-extend byte/half loads
//   req_addr, req_wdata   byte address, store data (low bits for b/h)
//   rsp_valid             one-cycle response pulse
//   rsp_rdata, rsp_err    registered load data (0 for stores), error flag
//   busy                  controller not in IDLE
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam int         BA  = AW + 2;          // byte-address bits kept
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_cnt;
  logic            r_we, r_uns;
  logic [1:0]      r_size;
  logic [BA-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  // Upper address bits only wrap the array; fold them away explicitly.
  if (ADDR_W > BA) begin : g_addr_hi
    logic w_unused_addr;
    assign w_unused_addr = ^req_addr[ADDR_W-1:BA];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == LAT) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Wait counter runs 1..LATENCY while in WAIT, 0 elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                r_cnt <= 3'd0;
    else if (w_next == S_WAIT) r_cnt <= (r_state == S_WAIT) ? r_cnt + 3'd1 : 3'd1;
    else                       r_cnt <= 3'd0;
  end

  // Request capture on acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_we    <= req_we;
      r_uns   <= req_unsigned;
      r_size  <= req_size;
      r_addr  <= req_addr[BA-1:0];
      r_wdata <= req_wdata;
    end
  end

  // The access executes on the edge entering RESP. With LATENCY==0 that is
  // the accepting edge itself, so operands come straight from the inputs.
  logic            w_from_in;
  logic            w_op_we, w_op_uns;
  logic [1:0]      w_op_size;
  logic [BA-1:0]   w_op_addr;
  logic [31:0]     w_op_wdata;
  logic            w_go;

  assign w_from_in  = (r_state == S_IDLE);
  assign w_op_we    = w_from_in ? req_we            : r_we;
  assign w_op_uns   = w_from_in ? req_unsigned      : r_uns;
  assign w_op_size  = w_from_in ? req_size          : r_size;
  assign w_op_addr  = w_from_in ? req_addr[BA-1:0]  : r_addr;
  assign w_op_wdata = w_from_in ? req_wdata         : r_wdata;
  // Gating with reset drops a store that would land while reset is held.
  assign w_go       = reset && (w_next == S_RESP) && (r_state != S_RESP);

  // ---------------- access decode ----------------
  logic [1:0]    w_size_e;   // effective size
  logic [1:0]    w_lo;       // effective byte offset within the word
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_idx = w_op_addr[BA-1:2];

`ifdef DMEM_ERR_EN
  logic w_mis;
  assign w_mis    = (w_op_size == 2'b01 && w_op_addr[0]) ||
                    (w_op_size == 2'b10 && w_op_addr[1:0] != 2'b00);
  assign w_err    = w_mis || (w_op_size == 2'b11);
  assign w_size_e = w_op_size;
  assign w_lo     = w_op_addr[1:0];
`else
  assign w_err    = 1'b0;
  assign w_size_e = (w_op_size == 2'b11) ? 2'b10 : w_op_size;
  always_comb begin
    case (w_size_e)
      2'b00:   w_lo = w_op_addr[1:0];
      2'b01:   w_lo = {w_op_addr[1], 1'b0};
      default: w_lo = 2'b00;
    endcase
  end
`endif

  // ---------------- store lanes ----------------
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata_l;

  always_comb begin
    w_wmask   = 4'b1111;
    w_wdata_l = w_op_wdata;
    case (w_size_e)
      2'b00: begin
        w_wmask   = 4'b0001 << w_lo;
        w_wdata_l = {4{w_op_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask   = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata_l = {2{w_op_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Array is never reset; only the selected byte lanes are written.
  always_ff @(posedge clock) begin
    if (w_go && w_op_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_l[8*b +: 8];
      end
    end
  end

  // ---------------- load extract / extend ----------------
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_rdata_n;

  assign w_word = r_mem[w_idx];
  assign w_half = w_lo[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (w_lo)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    case (w_size_e)
      2'b00:   w_ld = w_op_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ld = w_op_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ld = w_word;
    endcase
  end

  assign w_rdata_n = (w_op_we || w_err) ? 32'd0 : w_ld;

  // Response data is loaded on entry to RESP and held until the next one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_go) begin
      r_rdata <= w_rdata_n;
      r_err   <= w_err;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: four instances with LATENCY 1, 0, 7, 3.
// Expected responses go into a scoreboard queue when a request is driven
// and are popped and compared when the response pulse arrives.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       rst_n, rv, rwe, runs, rdy, vld, err, bsy;
  logic [3:0][1:0]  rsz;
  logic [3:0][31:0] raddr, rwd, rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    int          lat;
  } exp_t;
  exp_t sb[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_ctrl #(
      .ADDR_W(32), .DEPTH_WORDS(64),
      .LATENCY(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 3)
    ) u_dut (
      .clock(clk), .reset(rst_n[g]),
      .req_valid(rv[g]), .req_ready(rdy[g]), .req_we(rwe[g]),
      .req_size(rsz[g]), .req_unsigned(runs[g]), .req_addr(raddr[g]),
      .req_wdata(rwd[g]), .rsp_valid(vld[g]), .rsp_rdata(rdata[g]),
      .rsp_err(err[g]), .busy(bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on instance k; latency is counted in edges from acceptance.
  task automatic req(input int k, input string tag, input logic we,
                     input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic ee);
    exp_t x;
    int   n;
    int   lat;
    x.rd  = erd;
    x.e   = ee;
    x.lat = (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? 8 : 4;
    sb.push_back(x);
    @(negedge clk);
    rwe[k] = we; rsz[k] = sz; runs[k] = uns; raddr[k] = a; rwd[k] = wd;
    rv[k] = 1'b1;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 rv[k] = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (vld[k] === 1'b1) break;
    end
    x = sb.pop_front();
    chk({tag, " latency"}, lat, x.lat);
    chk({tag, " rdata"}, rdata[k], x.rd);
    chk({tag, " err"}, {31'd0, err[k]}, {31'd0, x.e});
    @(negedge clk);
    chk({tag, " pulse width"}, {31'd0, vld[k]}, 32'd0);
  endtask

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

  initial begin
    rst_n = 4'h0; rv = '0; rwe = '0; runs = '0; rsz = '0; raddr = '0; rwd = '0;

    // ---- reset ----
    repeat (3) @(negedge clk);
    rst_n = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset ready", {31'd0, rdy[k]}, 32'd1);
      chk("reset valid", {31'd0, vld[k]}, 32'd0);
      chk("reset busy",  {31'd0, bsy[k]}, 32'd0);
      chk("reset rdata", rdata[k], 32'd0);
      chk("reset err",   {31'd0, err[k]}, 32'd0);
    end

    // ---- word round trip, LATENCY=1 ----
    req(0, "sw 10",  1, SW, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req(0, "lw 10",  0, SW, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    repeat (3) @(negedge clk);
    chk("rdata hold", rdata[0], 32'hDEADBEEF);

    // ---- byte / half lanes and extension ----
    req(0, "sw 10 zero", 1, SW, 0, 32'h10, 32'h0, 32'h0, 0);
    req(0, "sb 13",  1, SB, 0, 32'h13, 32'hFFFFFF80, 32'h0, 0);
    req(0, "lw sb",  0, SW, 0, 32'h10, 32'h0, 32'h80000000, 0);
    req(0, "lb 13",  0, SB, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    req(0, "lbu 13", 0, SB, 1, 32'h13, 32'h0, 32'h00000080, 0);
    req(0, "sh 12",  1, SH, 0, 32'h12, 32'hABCD1234, 32'h0, 0);
    req(0, "lw sh",  0, SW, 0, 32'h10, 32'h0, 32'h12340000, 0);
    req(0, "sh 10",  1, SH, 0, 32'h10, 32'h00008001, 32'h0, 0);
    req(0, "lh 10",  0, SH, 0, 32'h10, 32'h0, 32'hFFFF8001, 0);
    req(0, "lhu 10", 0, SH, 1, 32'h10, 32'h0, 32'h00008001, 0);
    req(0, "sb 11",  1, SB, 0, 32'h11, 32'h0000007F, 32'h0, 0);
    req(0, "lw sb11", 0, SW, 0, 32'h10, 32'h0, 32'h12347F01, 0);
    req(0, "lb 11",  0, SB, 0, 32'h11, 32'h0, 32'h0000007F, 0);
    req(0, "lw unsigned", 0, SW, 1, 32'h10, 32'h0, 32'h12347F01, 0);

    // ---- address wrap ----
    req(0, "sw 100", 1, SW, 0, 32'h100, 32'hA5A5A5A5, 32'h0, 0);
    req(0, "lw 000", 0, SW, 0, 32'h000, 32'h0, 32'hA5A5A5A5, 0);
    req(0, "lw hi wrap", 0, SW, 0, 32'hFFFFFF00, 32'h0, 32'hA5A5A5A5, 0);

    // ---- latency sweep ----
    req(1, "L0 sw", 1, SW, 0, 32'h08, 32'h01020304, 32'h0, 0);
    req(1, "L0 lw", 0, SW, 0, 32'h08, 32'h0, 32'h01020304, 0);
    req(1, "L0 lb", 0, SB, 0, 32'h0B, 32'h0, 32'h00000001, 0);
    req(2, "L7 sw", 1, SW, 0, 32'h08, 32'hCAFE0001, 32'h0, 0);
    req(2, "L7 lw", 0, SW, 0, 32'h08, 32'h0, 32'hCAFE0001, 0);

    // ---- misaligned / reserved ----
    req(0, "sw 10 base", 1, SW, 0, 32'h10, 32'hCAFEF00D, 32'h0, 0);
`ifdef DMEM_ERR_EN
    req(0, "lw 11 mis",  0, SW, 0, 32'h11, 32'h0, 32'h0, 1);
    req(0, "sw 11 mis",  1, SW, 0, 32'h11, 32'h99999999, 32'h0, 1);
    req(0, "lw 10 kept", 0, SW, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0);
    req(0, "sh 11 mis",  1, SH, 0, 32'h11, 32'h00001111, 32'h0, 1);
    req(0, "lh 13 mis",  0, SH, 0, 32'h13, 32'h0, 32'h0, 1);
    req(0, "size11 ld",  0, SR, 0, 32'h10, 32'h0, 32'h0, 1);
    req(0, "lw 10 still", 0, SW, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0);
`else
    req(0, "lw 11 align", 0, SW, 0, 32'h11, 32'h0, 32'hCAFEF00D, 0);
    req(0, "sw 11 align", 1, SW, 0, 32'h11, 32'h99999999, 32'h0, 0);
    req(0, "lw 10 new",   0, SW, 0, 32'h10, 32'h0, 32'h99999999, 0);
    req(0, "lh 13 align", 0, SH, 0, 32'h13, 32'h0, 32'hFFFF9999, 0);
    req(0, "size11 st",   1, SR, 0, 32'h10, 32'h76543210, 32'h0, 0);
    req(0, "size11 ld",   0, SR, 0, 32'h12, 32'h0, 32'h76543210, 0);
`endif

    // ---- reset mid-operation, LATENCY=3 ----
    req(3, "prior sw 20", 1, SW, 0, 32'h20, 32'h55667788, 32'h0, 0);
    @(negedge clk);
    rwe[3] = 1'b1; rsz[3] = SW; runs[3] = 1'b0; raddr[3] = 32'h20;
    rwd[3] = 32'h11112222; rv[3] = 1'b1;
    @(posedge clk);
    #1 rv[3] = 1'b0;
    @(negedge clk);
    chk("wait busy",  {31'd0, bsy[3]}, 32'd1);
    chk("wait ready", {31'd0, rdy[3]}, 32'd0);
    rst_n[3] = 1'b0;
    #1;
    chk("midreset ready", {31'd0, rdy[3]}, 32'd1);
    chk("midreset busy",  {31'd0, bsy[3]}, 32'd0);
    chk("midreset valid", {31'd0, vld[3]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n[3] = 1'b1;
    req(3, "lw 20 after abort", 0, SW, 0, 32'h20, 32'h0, 32'h55667788, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
